clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Receive-side companion to the programmable clock divider.
- Samples a slow, asynchronous divided clock (or any square wave) on `sig_in` and measures it against the fast system clock `clk_in`.
- Reports period and high time in `clk_in` cycles, flags loss of signal, and indicates when the measured period has settled.
- Used on-chip and on the bench to confirm the divider's output frequency and duty cycle.

Parameters:
- CNT_WIDTH, 32: width of period/high-time counters and outputs.
- SYNC_STAGES, 2: synchroniser flops on `sig_in` (legal range 2..4).
- TIMEOUT_CYCLES, 200000000: `clk_in` cycles without a rising edge before `timeout` asserts. Must be < 2^CNT_WIDTH.
- STABLE_COUNT, 4: consecutive matching measurements required for `stable` (legal range 1..15).
- TOL, 0: allowed absolute difference in cycles between successive periods that still counts as a match.

Ports:
- clk_in, input, 1: system clock; all logic on rising edge.
- nrst, input, 1: synchronous active-low reset.
- sig_in, input, 1: asynchronous signal under measurement.
- enable, input, 1: measurement enable.
- period, output, CNT_WIDTH: last complete period in `clk_in` cycles.
- high_time, output, CNT_WIDTH: high-phase length of that same period.
- meas_valid, output, 1: one-cycle pulse when `period`/`high_time` update.
- stable, output, 1: period has matched within TOL for STABLE_COUNT consecutive measurements.
- timeout, output, 1: no rising edge within TIMEOUT_CYCLES.

Behaviour:
- Interface (already decided): reset `nrst` is synchronous and active-low; clock is `clk_in`.
- Reset:
  - All outputs are 0.
  - Synchroniser and edge-detect flops are 0.
  - Counters and match count are 0.
  - FSM goes to IDLE.
  - Reset asserted mid-measurement discards the partial measurement immediately.
- Input path:
  - `sig_in` passes through SYNC_STAGES flops, then one previous-value flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Latency from a `sig_in` edge (meeting setup) to the rise/fall strobe is SYNC_STAGES+1 cycles. Strobes are internal.
- FSM states: IDLE, ARM, MEASURE.
- IDLE:
  - Entered when `enable` = 0; checked every cycle with priority over everything except reset.
  - Counters cleared; `stable`, `timeout` and `meas_valid` = 0; `period`/`high_time` hold.
  - `enable` = 1 -> ARM.
- ARM:
  - Waits for the first rise. The running counter `run_cnt` counts here for timeout only.
  - rise -> MEASURE with `run_cnt` = 0 and `high_cnt` = 0.
- MEASURE:
  - Each cycle: `run_cnt` += 1.
  - On fall: `high_cnt` <= `run_cnt` + 1.
  - On rise:
    - `period` <= `run_cnt` + 1 and `high_time` <= `high_cnt`.
    - `meas_valid` = 1 in the following cycle.
    - `run_cnt` <= 0 and `high_cnt` <= 0.
    - `timeout` <= 0.
    - Remain in MEASURE.
  - Example: a square wave of P cycles with H cycles high gives `period` = P and `high_time` = H.
- Timeout:
  - In ARM or MEASURE, when `run_cnt` = TIMEOUT_CYCLES-1 with no rise in that cycle: `timeout` <= 1, `stable` <= 0, match count <= 0, `run_cnt` <= 0, state -> ARM.
  - `period`/`high_time` hold.
  - `timeout` stays high until the next `meas_valid`.
  - A rise in the same cycle as the terminal count wins; no timeout.
  - `run_cnt` never wraps.
- Stability:
  - On each measurement, compare the new period with the previous one (stored internally).
  - If |new-prev| <= TOL, the match count increments, saturating at STABLE_COUNT.
  - Otherwise the match count = 0.
  - The first measurement after ARM always sets the match count to 0.
  - `stable` = (match count == STABLE_COUNT), registered, and updates in the same cycle as `meas_valid`.
  - It therefore needs STABLE_COUNT+1 measurements.
- Limits:
  - Minimum measurable period is 2 cycles (1 high, 1 low).
  - A `sig_in` equal to `clk_in` (the divider's scale-0 passthrough) or faster aliases. Same-edge sampling of `clk_in` reads constant and yields a timeout; this is the required, documented result.
  - Glitches shorter than one cycle may be missed; no filtering.

Test Plan:
- 50% wave, 10-cycle period, `enable`=1 -> first `meas_valid` after the second rise with `period`=10, `high_time`=5. `meas_valid` then pulses every 10 cycles. `stable`=1 coincident with the 5th `meas_valid` (STABLE_COUNT=4).
- 30% duty wave, 20-cycle period (6 high) -> `period`=20, `high_time`=6. Then 2-cycle toggling (period 2, 1 high) -> `period`=2, `high_time`=1 with `stable` dropped on the first changed value.
- TIMEOUT_CYCLES=64, `sig_in` held 1 after one rise -> `timeout`=1 exactly 64 cycles after the `run_cnt` clear. `period` holds, `stable`=0. A restart square wave of period 8 clears `timeout` on the first new `meas_valid`.
- TOL=1, period alternating 10/11 -> `stable` reaches 1. Alternating 10/12 -> `stable` stays 0.
- `nrst` low for 1 cycle mid-MEASURE -> all outputs 0 next cycle. The first `meas_valid` afterwards is after two fresh rises.
- `enable` dropped mid-period -> no `meas_valid`, `stable`=0, `period` held. Re-enable -> the first result requires two new rises.

Source files
------------

// File: rtl/clock_period_meter.sv
// ============================================================================
// clock_period_meter
//
// Receive-side companion to the programmable clock divider. Samples a slow,
// asynchronous square wave on sig_in and measures it against clk_in. Each
// complete period (rising edge to rising edge) produces a new period /
// high_time pair, announced by a one-cycle meas_valid pulse. Loss of signal
// raises timeout. A run of matching periods raises stable.
//
// Ports
//   clk_in     in   1          system clock, all logic on the rising edge
//   nrst       in   1          synchronous active-low reset
//   sig_in     in   1          asynchronous signal under measurement
//   enable     in   1          measurement enable (low forces IDLE)
//   period     out  CNT_WIDTH  last complete period in clk_in cycles
//   high_time  out  CNT_WIDTH  high-phase length of that same period
//   meas_valid out  1          one-cycle pulse when period/high_time update
//   stable     out  1          period matched within TOL for STABLE_COUNT
//                              consecutive measurements
//   timeout    out  1          no rising edge within TIMEOUT_CYCLES
//
// Inputs faster than clk_in/2 alias. In particular a sig_in that is clk_in
// itself is sampled at the same phase every cycle, reads constant and ends in
// timeout. Glitches shorter than a clk_in cycle may be missed.
// ============================================================================
module clock_period_meter #(
    parameter int CNT_WIDTH      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int STABLE_COUNT   = 4,
    parameter int TOL            = 0
) (
    input  logic                 clk_in,
    input  logic                 nrst,
    input  logic                 sig_in,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 stable,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TOL_C     = CNT_WIDTH'(TOL);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]           MATCH_MAX = 4'(STABLE_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [CNT_WIDTH-1:0] abs_diff(
        input logic [CNT_WIDTH-1:0] a,
        input logic [CNT_WIDTH-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= MATCH_MAX) ? MATCH_MAX : (c + 4'd1);
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: synchroniser chain, stage p1: previous-value flop
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign rise = sync_p0[SYNC_STAGES-1] & ~prev_p1;
    assign fall = ~sync_p0[SYNC_STAGES-1] & prev_p1;

    // ------------------------------------------------------------------
    // Stage p2: measurement FSM and result registers
    // ------------------------------------------------------------------
    state_t                 state;
    logic [CNT_WIDTH-1:0]   run_cnt;
    logic [CNT_WIDTH-1:0]   high_cnt;
    logic [CNT_WIDTH-1:0]   prev_period;
    logic [3:0]             match_cnt;
    logic                   first_meas;

    logic [CNT_WIDTH-1:0]   meas_now;
    logic [3:0]             match_next;
    logic                   at_terminal;

    // Period that would be latched if a rise is seen this cycle, and the
    // match count that measurement would produce. The very first
    // measurement after ARM has no meaningful predecessor, so it starts the
    // run at zero.
    always_comb begin
        meas_now    = run_cnt + CNT_ONE;
        at_terminal = (run_cnt == TO_LAST);
        match_next  = 4'd0;
        if (!first_meas && (abs_diff(meas_now, prev_period) <= TOL_C)) begin
            match_next = sat_inc(match_cnt);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state      <= IDLE;
            run_cnt    <= '0;
            high_cnt   <= '0;
            match_cnt  <= 4'd0;
            first_meas <= 1'b1;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            stable     <= 1'b0;
            timeout    <= 1'b0;
        end else if (!enable) begin
            // Disable wins over everything but reset; results are held.
            state      <= IDLE;
            run_cnt    <= '0;
            high_cnt   <= '0;
            match_cnt  <= 4'd0;
            first_meas <= 1'b1;
            meas_valid <= 1'b0;
            stable     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= ARM;
                    run_cnt    <= '0;
                    high_cnt   <= '0;
                    first_meas <= 1'b1;
                end

                ARM: begin
                    if (rise) begin
                        state    <= MEASURE;
                        run_cnt  <= '0;
                        high_cnt <= '0;
                    end else if (at_terminal) begin
                        timeout   <= 1'b1;
                        stable    <= 1'b0;
                        match_cnt <= 4'd0;
                        run_cnt   <= '0;
                    end else begin
                        run_cnt <= run_cnt + CNT_ONE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        // A rise on the terminal count still counts as a
                        // measurement, so it is checked first.
                        period     <= meas_now;
                        high_time  <= high_cnt;
                        meas_valid <= 1'b1;
                        timeout    <= 1'b0;
                        run_cnt    <= '0;
                        high_cnt   <= '0;
                        match_cnt  <= match_next;
                        stable     <= (match_next == MATCH_MAX);
                        first_meas <= 1'b0;
                    end else if (at_terminal) begin
                        state      <= ARM;
                        timeout    <= 1'b1;
                        stable     <= 1'b0;
                        match_cnt  <= 4'd0;
                        run_cnt    <= '0;
                        high_cnt   <= '0;
                        first_meas <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + CNT_ONE;
                        if (fall) begin
                            high_cnt <= meas_now;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reference period for the next comparison. Only read after a first
    // measurement has written it, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (enable && (state == MEASURE) && rise) begin
            prev_period <= meas_now;
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter. Two instances share the stimulus:
// u0 has TOL=0, u1 has TOL=1; both use TIMEOUT_CYCLES=64 and STABLE_COUNT=4.
module tb_clock_period_meter;

    localparam int CW = 32;

    logic          clk_in = 1'b0;
    logic          nrst   = 1'b0;
    logic          sig_in = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] period0, high0, period1, high1;
    logic          mv0, st0, to0, mv1, st1, to1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-measurement record of u0 (and u1 stable alongside).
    int          nrec = 0;
    logic [31:0] rec_period [64];
    logic [31:0] rec_high   [64];
    logic        rec_stable [64];
    logic        rec_stable1[64];
    int          rec_cyc    [64];

    always #5 clk_in = ~clk_in;

    clock_period_meter #(.CNT_WIDTH(CW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64),
                         .STABLE_COUNT(4), .TOL(0)) u0 (
        .clk_in(clk_in), .nrst(nrst), .sig_in(sig_in), .enable(enable),
        .period(period0), .high_time(high0), .meas_valid(mv0),
        .stable(st0), .timeout(to0));

    clock_period_meter #(.CNT_WIDTH(CW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64),
                         .STABLE_COUNT(4), .TOL(1)) u1 (
        .clk_in(clk_in), .nrst(nrst), .sig_in(sig_in), .enable(enable),
        .period(period1), .high_time(high1), .meas_valid(mv1),
        .stable(st1), .timeout(to1));

    // One clock: sample outputs 1 unit after the edge, log any measurement,
    // then drive the next sig_in value.
    task automatic step(input logic s);
        @(posedge clk_in);
        #1;
        cyc++;
        if (mv0 && nrec < 64) begin
            rec_period[nrec]  = period0;
            rec_high[nrec]    = high0;
            rec_stable[nrec]  = st0;
            rec_stable1[nrec] = st1;
            rec_cyc[nrec]     = cyc;
            nrec++;
        end
        sig_in = s;
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < p; k++)
                step(k < h);
    endtask

    task automatic hold(input int n, input logic s);
        for (int i = 0; i < n; i++) step(s);
    endtask

    task automatic test_reset;
        nrst = 1'b0; enable = 1'b1; sig_in = 1'b0;
        hold(3, 1'b0);
        total++; if (period0 !== 32'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period0); end
        total++; if (high0 !== 32'd0) begin bad++; $display("FAIL reset_high got=%0d want=0", high0); end
        total++; if ({mv0, st0, to0, mv1, st1, to1} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=000000", {mv0, st0, to0, mv1, st1, to1}); end
        nrst = 1'b1;
    endtask

    task automatic test_square_10;
        hold(4, 1'b0);
        nrec = 0;
        wave(10, 5, 6);
        total++; if (nrec !== 5) begin bad++; $display("FAIL sq10_count got=%0d want=5", nrec); end
        total++; if (rec_period[0] !== 32'd10) begin bad++; $display("FAIL sq10_period got=%0d want=10", rec_period[0]); end
        total++; if (rec_high[0] !== 32'd5) begin bad++; $display("FAIL sq10_high got=%0d want=5", rec_high[0]); end
        total++; if (rec_cyc[1] - rec_cyc[0] !== 10) begin bad++; $display("FAIL sq10_spacing got=%0d want=10", rec_cyc[1] - rec_cyc[0]); end
        total++; if (rec_stable[3] !== 1'b0) begin bad++; $display("FAIL sq10_stable_4th got=%b want=0", rec_stable[3]); end
        total++; if (rec_stable[4] !== 1'b1) begin bad++; $display("FAIL sq10_stable_5th got=%b want=1", rec_stable[4]); end
    endtask

    task automatic test_duty_and_fast;
        nrec = 0;
        wave(20, 6, 7);
        total++; if (rec_period[0] !== 32'd10) begin bad++; $display("FAIL duty_boundary got=%0d want=10", rec_period[0]); end
        total++; if (rec_period[1] !== 32'd20) begin bad++; $display("FAIL duty_period got=%0d want=20", rec_period[1]); end
        total++; if (rec_high[1] !== 32'd6) begin bad++; $display("FAIL duty_high got=%0d want=6", rec_high[1]); end
        total++; if ({rec_stable[4], rec_stable[5]} !== 2'b01) begin bad++; $display("FAIL duty_stable got=%b want=01", {rec_stable[4], rec_stable[5]}); end
        wave(2, 1, 6);
        hold(5, 1'b0);
        total++; if (nrec !== 13) begin bad++; $display("FAIL fast_count got=%0d want=13", nrec); end
        total++; if (rec_period[8] !== 32'd2) begin bad++; $display("FAIL fast_period got=%0d want=2", rec_period[8]); end
        total++; if (rec_high[8] !== 32'd1) begin bad++; $display("FAIL fast_high got=%0d want=1", rec_high[8]); end
        total++; if ({rec_stable[7], rec_stable[8]} !== 2'b10) begin bad++; $display("FAIL fast_stable_drop got=%b want=10", {rec_stable[7], rec_stable[8]}); end
    endtask

    task automatic test_timeout;
        int t_to;
        t_to = -1;
        nrec = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1);
            if (to0 && t_to < 0) t_to = cyc;
        end
        total++; if (nrec !== 1) begin bad++; $display("FAIL to_meas_count got=%0d want=1", nrec); end
        total++; if (t_to - rec_cyc[0] !== 64) begin bad++; $display("FAIL to_delay got=%0d want=64", t_to - rec_cyc[0]); end
        total++; if (period0 !== 32'd7) begin bad++; $display("FAIL to_period_hold got=%0d want=7", period0); end
        total++; if (high0 !== 32'd1) begin bad++; $display("FAIL to_high_hold got=%0d want=1", high0); end
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL to_stable got=%b want=0", st0); end
        hold(4, 1'b0);
        total++; if (to0 !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", to0); end
        nrec = 0;
        wave(8, 4, 3);
        total++; if (nrec !== 2) begin bad++; $display("FAIL restart_count got=%0d want=2", nrec); end
        total++; if (rec_period[0] !== 32'd8) begin bad++; $display("FAIL restart_period got=%0d want=8", rec_period[0]); end
        total++; if (rec_high[0] !== 32'd4) begin bad++; $display("FAIL restart_high got=%0d want=4", rec_high[0]); end
        total++; if (to0 !== 1'b0) begin bad++; $display("FAIL restart_timeout got=%b want=0", to0); end
    endtask

    task automatic test_tolerance;
        int ones;
        nrec = 0;
        for (int i = 0; i < 4; i++) begin wave(10, 5, 1); wave(11, 5, 1); end
        total++; if (rec_stable1[4] !== 1'b0) begin bad++; $display("FAIL tol1_early got=%b want=0", rec_stable1[4]); end
        total++; if (rec_stable1[5] !== 1'b1) begin bad++; $display("FAIL tol1_stable got=%b want=1", rec_stable1[5]); end
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL tol0_alt got=%b want=0", st0); end
        nrec = 0;
        for (int i = 0; i < 4; i++) begin wave(10, 5, 1); wave(12, 5, 1); end
        ones = 0;
        for (int i = 2; i < 8; i++) if (rec_stable1[i] === 1'b1) ones++;
        total++; if (ones !== 0) begin bad++; $display("FAIL tol1_wide_stable got=%0d want=0", ones); end
        total++; if (rec_period[2] !== 32'd12) begin bad++; $display("FAIL tol1_wide_period got=%0d want=12", rec_period[2]); end
    endtask

    task automatic test_reset_mid;
        wave(10, 5, 2);
        @(posedge clk_in); #1; nrst = 1'b0; sig_in = 1'b0;
        @(posedge clk_in); #1;
        total++; if ({period0, high0} !== 64'd0) begin bad++; $display("FAIL midrst_values got=%0d/%0d want=0/0", period0, high0); end
        total++; if ({mv0, st0, to0} !== 3'b0) begin bad++; $display("FAIL midrst_flags got=%b want=000", {mv0, st0, to0}); end
        nrst = 1'b1;
        nrec = 0;
        wave(10, 5, 3);
        total++; if (nrec !== 2) begin bad++; $display("FAIL midrst_count got=%0d want=2", nrec); end
        total++; if (rec_period[0] !== 32'd10) begin bad++; $display("FAIL midrst_period got=%0d want=10", rec_period[0]); end
    endtask

    task automatic test_enable_drop;
        wave(10, 5, 4);
        total++; if (st0 !== 1'b1) begin bad++; $display("FAIL en_pre_stable got=%b want=1", st0); end
        hold(5, 1'b1);
        hold(2, 1'b0);
        nrec = 0;
        enable = 1'b0;
        hold(3, 1'b0); hold(3, 1'b1); hold(6, 1'b0);
        total++; if (nrec !== 0) begin bad++; $display("FAIL en_off_valid got=%0d want=0", nrec); end
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL en_off_stable got=%b want=0", st0); end
        total++; if (period0 !== 32'd10) begin bad++; $display("FAIL en_off_period got=%0d want=10", period0); end
        enable = 1'b1;
        nrec = 0;
        wave(10, 5, 3);
        total++; if (nrec !== 2) begin bad++; $display("FAIL en_on_count got=%0d want=2", nrec); end
        total++; if (rec_period[0] !== 32'd10) begin bad++; $display("FAIL en_on_period got=%0d want=10", rec_period[0]); end
    endtask

    initial begin
        test_reset;
        test_square_10;
        test_duty_and_fast;
        test_timeout;
        test_tolerance;
        test_reset_mid;
        test_enable_drop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
